ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit: the initiator side of the instruction-memory interface. Owns the architectural PC, issues one word-aligned fetch request at a time to the instruction memory, and captures the 32-bit response. Presents each fetched instruction with its PC to decode over a valid/ready handshake. Applies branch/jump redirects, discarding any in-flight fetch.

## Interface
Parameters:
- `PC_RST`, 64'h8000_0000, PC fetched first after reset
- `XLEN`, 64, PC/address width
- `ILEN`, 32, instruction width
- `NOP_INST`, 32'h0000_0013, reset value of `id_inst`

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `imem_req_valid` out 1: fetch request valid
- `imem_req_ready` in 1: memory accepts request this cycle
- `imem_req_addr` out XLEN: fetch address, always 4-byte aligned
- `imem_resp_valid` in 1: response valid, one-cycle pulse, one per accepted request
- `imem_resp_inst` in ILEN: fetched instruction
- `id_valid` out 1: instruction available to decode
- `id_ready` in 1: decode accepts
- `id_pc` out XLEN: PC of `id_inst`
- `id_inst` out ILEN: instruction
- `redirect_valid` in 1: one-cycle redirect request
- `redirect_pc` in XLEN: redirect target; bits [1:0] are cleared internally

## Operation
- States: BOOT, REQ, WAIT, HOLD, FLUSH. Exactly one request is outstanding at most.
- BOOT: entered on reset; `imem_req_valid`=0. Next cycle -> REQ.
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc.
  - Handshake (`valid & ready`) -> WAIT.
  - Redirect without handshake: pc<=target, stay in REQ. A request is committed only on handshake.
  - Redirect with handshake in the same cycle: pc<=target, -> FLUSH (the old-PC response is discarded).
- WAIT: on `imem_resp_valid`: `id_inst`<=resp, `id_pc`<=pc, `id_valid`<=1, pc<=pc+4, -> HOLD. Redirect in WAIT: pc<=target, -> FLUSH.
  - Redirect and response in the same cycle: the response is discarded, pc<=target, -> REQ.
- HOLD: `id_valid`=1, outputs stable until the handshake. On `id_valid & id_ready` -> REQ and `id_valid`<=0.
  - Redirect in HOLD: `id_valid`<=0, pc<=target, -> REQ.
  - Redirect and handshake in the same cycle: the transfer counts (squashing is decode's job), pc<=target, -> REQ.
- FLUSH: wait for `imem_resp_valid`, discard it, -> REQ. A further redirect in FLUSH updates pc and stays in FLUSH.
- Arithmetic: pc+4 wraps modulo 2^XLEN. `imem_req_addr[1:0]` is always 0.
- Reset mid-operation: immediate return to BOOT. Any response arriving after reset is ignored; the memory side must drop its in-flight state on the same reset.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=PC_RST, `id_valid`=0, `id_pc`=PC_RST, `id_inst`=NOP_INST, pc=PC_RST.
- First request is issued on the 2nd rising edge after `rst_n` deasserts (BOOT lasts 1 cycle).
- `imem_resp_valid` may arrive at the earliest 1 cycle after the request handshake; there is no upper bound.
- `id_valid` rises the cycle after `imem_resp_valid`.
- Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD) with a zero-wait memory and `id_ready`=1.
- Redirect to the first request at the new PC: 1 cycle from REQ/HOLD; from WAIT/FLUSH, 1 cycle after the discarded response.
- All outputs are registered. There is no combinational path from `id_ready` or `redirect_valid` to any output.

## Configuration
- `IFU_PERF_CNT_EN` defined:
  - Adds outputs `perf_fetch_cnt` (64-bit; counts `id_valid & id_ready` transfers).
  - Adds outputs `perf_flush_cnt` (64-bit; counts discarded responses).
  - Both reset to 0, wrap at 2^64.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`: `ifu_state_e` enum, `XLEN`/`ILEN` constants, `PC_RST`, `NOP_INST`.
- Single module, no sub-modules. The perf counters are inline under the macro.

## Test plan
- Reset release, zero-wait memory, `id_ready`=1 -> requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; `id_pc` matches each; one instruction every 3 cycles.
- `imem_req_ready` held low 5 cycles -> `imem_req_valid` and `imem_req_addr` stay stable, and there is no `id_valid`.
- `id_ready` low 4 cycles in HOLD -> `id_pc`/`id_inst` stable, and no new request is issued.
- Redirect to 0x8000_0103 while in WAIT -> the old response is dropped, `perf_flush_cnt`=1, and the next request goes to 0x8000_0100.
- Redirect in HOLD concurrent with `id_ready` -> the transfer counts (`perf_fetch_cnt`+1), and the next request goes to the target.
- `rst_n` asserted in WAIT, response arrives after release -> the response is ignored; outputs return to reset values; the first request is at PC_RST.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, reset PC, the canonical
// NOP encoding and the fetch-unit state encoding.
package cpu_pkg;

   localparam int          XLEN     = 64;
   localparam int          ILEN     = 32;
   localparam logic [63:0] PC_RST   = 64'h8000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [2:0] {
      BOOT,
      REQ,
      WAIT,
      HOLD,
      FLUSH
   } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Bus bundles used by the instruction fetch unit.
//   ifu_imem_if : fetch request/response channel to instruction memory
//                 master = fetch unit, slave = memory
//   ifu_id_if   : fetched-instruction handoff to decode
//                 master = fetch unit, slave = decode
interface ifu_imem_if #(
   parameter int XLEN = cpu_pkg::XLEN,
   parameter int ILEN = cpu_pkg::ILEN
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [ILEN-1:0] imem_resp_inst;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_inst
   );
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_inst
   );
endinterface

interface ifu_id_if #(
   parameter int XLEN = cpu_pkg::XLEN,
   parameter int ILEN = cpu_pkg::ILEN
);
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   logic [ILEN-1:0] id_inst;

   modport master (
      output id_valid, id_pc, id_inst,
      input  id_ready
   );
   modport slave (
      input  id_valid, id_pc, id_inst,
      output id_ready
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit. Owns the PC, keeps at most one request outstanding
// to instruction memory, and hands each fetched word plus its PC to decode.
// Redirects retarget the PC and discard any response already in flight.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem            ifu_imem_if.master : request/response to instruction memory
//   id              ifu_id_if.master   : instruction/PC handoff to decode
//   redirect_valid  one-cycle redirect strobe
//   redirect_pc     redirect target (low two bits ignored)
//   perf_fetch_cnt  decode transfers           (only with IFU_PERF_CNT_EN)
//   perf_flush_cnt  discarded memory responses (only with IFU_PERF_CNT_EN)
//
// Build option: define IFU_PERF_CNT_EN to add the two performance counters.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// REQ   | request at pc offered, waiting for memory handshake
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction presented to decode, waiting for id_ready
// FLUSH | waiting for a stale response to drop after a redirect
module ifu_fetch import cpu_pkg::*; #(
   parameter int              XLEN     = cpu_pkg::XLEN,
   parameter int              ILEN     = cpu_pkg::ILEN,
   parameter logic [XLEN-1:0] PC_RST   = cpu_pkg::PC_RST,
   parameter logic [ILEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
   input  logic            clk,
   input  logic            rst_n,
   ifu_imem_if.master      imem,
   ifu_id_if.master        id,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [63:0]     perf_fetch_cnt,
   output logic [63:0]     perf_flush_cnt
`endif
);

   ifu_state_e      state, stateNext;
   logic [XLEN-1:0] pc, pcNext;
   logic [XLEN-1:0] idPc, idPcNext;
   logic [ILEN-1:0] idInst, idInstNext;
   logic            idValid, idValidNext;
   logic            reqValid;
   logic            reqHs;
   logic [XLEN-1:0] redirectTarget;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   assign redirectTarget = redirect_pc & ALIGN_MASK;
   assign reqHs          = reqValid & imem.imem_req_ready;

   always_comb begin
      stateNext   = state;
      pcNext      = pc;
      idPcNext    = idPc;
      idInstNext  = idInst;
      idValidNext = idValid;
      case (state)
         BOOT: stateNext = REQ;
         REQ: begin
            if (redirect_valid) begin
               pcNext    = redirectTarget;
               // An accepted old-PC request still owes a response.
               stateNext = reqHs ? FLUSH : REQ;
            end else if (reqHs) begin
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               pcNext    = redirectTarget;
               stateNext = imem.imem_resp_valid ? REQ : FLUSH;
            end else if (imem.imem_resp_valid) begin
               idInstNext  = imem.imem_resp_inst;
               idPcNext    = pc;
               idValidNext = 1'b1;
               pcNext      = pc + XLEN'(4);
               stateNext   = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               idValidNext = 1'b0;
               pcNext      = redirectTarget;
               stateNext   = REQ;
            end else if (id.id_ready) begin
               idValidNext = 1'b0;
               stateNext   = REQ;
            end
         end
         FLUSH: begin
            if (redirect_valid) pcNext = redirectTarget;
            if (imem.imem_resp_valid) stateNext = REQ;
         end
         default: stateNext = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BOOT;
         pc       <= PC_RST & ALIGN_MASK;
         idPc     <= PC_RST;
         idInst   <= NOP_INST;
         idValid  <= 1'b0;
         reqValid <= 1'b0;
      end else begin
         state    <= stateNext;
         pc       <= pcNext;
         idPc     <= idPcNext;
         idInst   <= idInstNext;
         idValid  <= idValidNext;
         // Registered copy of "in REQ" keeps the request strobe glitch-free.
         reqValid <= (stateNext == REQ);
      end
   end

   assign imem.imem_req_valid = reqValid;
   assign imem.imem_req_addr  = pc;
   assign id.id_valid         = idValid;
   assign id.id_pc            = idPc;
   assign id.id_inst          = idInst;

`ifdef IFU_PERF_CNT_EN
   logic idTransfer;
   logic respDiscard;

   assign idTransfer  = idValid & id.id_ready;
   // Responses dropped: redirect racing a response in WAIT, or any in FLUSH.
   assign respDiscard = imem.imem_resp_valid &
                        (((state == WAIT) & redirect_valid) | (state == FLUSH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= 64'd0;
         perf_flush_cnt <= 64'd0;
      end else begin
         if (idTransfer)  perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
         if (respDiscard) perf_flush_cnt <= perf_flush_cnt + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch. A simple memory responder is folded into the
// step task: a request accepted on an edge is answered memLat cycles later.
module tb_ifu_fetch;
   import cpu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
   logic [63:0] perf_fetch_cnt;
   logic [63:0] perf_flush_cnt;
`endif

   ifu_imem_if imemBus ();
   ifu_id_if   idBus ();

   ifu_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem           (imemBus),
      .id             (idBus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   bit          memAuto;
   int          memLat;
   int          pendCnt;
   logic [63:0] pendAddr;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      if (memAuto && imemBus.imem_req_valid && imemBus.imem_req_ready) begin
         pendAddr = imemBus.imem_req_addr;
         pendCnt  = memLat;
      end
      @(posedge clk);
      #1;
      imemBus.imem_resp_valid = 1'b0;
      if (pendCnt > 0) begin
         pendCnt--;
         if (pendCnt == 0) begin
            imemBus.imem_resp_valid = 1'b1;
            imemBus.imem_resp_inst  = {16'hCAFE, pendAddr[15:0]};
         end
      end
   endtask

   task automatic apply_reset();
      rst_n                   = 1'b0;
      imemBus.imem_req_ready  = 1'b0;
      imemBus.imem_resp_valid = 1'b0;
      imemBus.imem_resp_inst  = 32'h0;
      idBus.id_ready          = 1'b0;
      redirect_valid          = 1'b0;
      redirect_pc             = 64'h0;
      pendCnt                 = 0;
      pendAddr                = 64'h0;
      memAuto                 = 1'b1;
      memLat                  = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      memAuto = 1'b0;
      pendCnt = 0;
      imemBus.imem_req_ready = 1'b1; imemBus.imem_resp_valid = 1'b0; imemBus.imem_resp_inst = 32'h0;
      idBus.id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (imemBus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", imemBus.imem_req_valid); end
      checks++; if (imemBus.imem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL rst_req_addr got=%h exp=80000000", imemBus.imem_req_addr); end
      checks++; if (idBus.id_valid !== 1'b0) begin failures++; $display("FAIL rst_id_valid got=%b exp=0", idBus.id_valid); end
      checks++; if (idBus.id_pc !== 64'h8000_0000) begin failures++; $display("FAIL rst_id_pc got=%h exp=80000000", idBus.id_pc); end
      checks++; if (idBus.id_inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_id_inst got=%h exp=00000013", idBus.id_inst); end
`ifdef IFU_PERF_CNT_EN
      checks++; if (perf_fetch_cnt !== 64'd0 || perf_flush_cnt !== 64'd0) begin failures++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_flush_cnt); end
`endif
      rst_n = 1'b1;
      step();   // BOOT -> REQ, first request visible before the 2nd edge
      checks++; if (imemBus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL boot_req_valid got=%b exp=1", imemBus.imem_req_valid); end
      checks++; if (imemBus.imem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL boot_req_addr got=%h exp=80000000", imemBus.imem_req_addr); end
   endtask

   task automatic test_stream();
      logic [63:0] expAddr;
      apply_reset();
      imemBus.imem_req_ready = 1'b1;
      idBus.id_ready = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         checks++; if (imemBus.imem_req_valid !== (k % 3 == 1)) begin failures++; $display("FAIL stream_req_valid k=%0d got=%b exp=%b", k, imemBus.imem_req_valid, (k % 3 == 1)); end
         checks++; if (idBus.id_valid !== (k % 3 == 0)) begin failures++; $display("FAIL stream_id_valid k=%0d got=%b exp=%b", k, idBus.id_valid, (k % 3 == 0)); end
         if (k % 3 == 1) begin
            expAddr = 64'h8000_0000 + 64'(4 * ((k - 1) / 3));
            checks++; if (imemBus.imem_req_addr !== expAddr) begin failures++; $display("FAIL stream_req_addr k=%0d got=%h exp=%h", k, imemBus.imem_req_addr, expAddr); end
         end
         if (k % 3 == 0) begin
            expAddr = 64'h8000_0000 + 64'(4 * (k / 3 - 1));
            checks++; if (idBus.id_pc !== expAddr) begin failures++; $display("FAIL stream_id_pc k=%0d got=%h exp=%h", k, idBus.id_pc, expAddr); end
            checks++; if (idBus.id_inst !== {16'hCAFE, expAddr[15:0]}) begin failures++; $display("FAIL stream_id_inst k=%0d got=%h exp=%h", k, idBus.id_inst, {16'hCAFE, expAddr[15:0]}); end
         end
      end
   endtask

   task automatic test_req_stall();
      apply_reset();
      idBus.id_ready = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         step();
         checks++; if (imemBus.imem_req_valid !== 1'b1 || imemBus.imem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL reqstall_req k=%0d got=%b/%h exp=1/80000000", k, imemBus.imem_req_valid, imemBus.imem_req_addr); end
         checks++; if (idBus.id_valid !== 1'b0) begin failures++; $display("FAIL reqstall_id_valid k=%0d got=%b exp=0", k, idBus.id_valid); end
      end
      imemBus.imem_req_ready = 1'b1;
      step();
      checks++; if (imemBus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reqstall_wait_req got=%b exp=0", imemBus.imem_req_valid); end
      step();
      checks++; if (idBus.id_valid !== 1'b1 || idBus.id_inst !== 32'hCAFE_0000) begin failures++; $display("FAIL reqstall_resp got=%b/%h exp=1/cafe0000", idBus.id_valid, idBus.id_inst); end
   endtask

   task automatic test_decode_stall();
      apply_reset();
      imemBus.imem_req_ready = 1'b1;
      repeat (3) step();
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (idBus.id_valid !== 1'b1 || idBus.id_pc !== 64'h8000_0000 || idBus.id_inst !== 32'hCAFE_0000) begin failures++; $display("FAIL idstall_hold k=%0d got=%b/%h/%h exp=1/80000000/cafe0000", k, idBus.id_valid, idBus.id_pc, idBus.id_inst); end
         checks++; if (imemBus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL idstall_no_req k=%0d got=%b exp=0", k, imemBus.imem_req_valid); end
      end
      idBus.id_ready = 1'b1;
      step();
      checks++; if (idBus.id_valid !== 1'b0) begin failures++; $display("FAIL idstall_release_valid got=%b exp=0", idBus.id_valid); end
      checks++; if (imemBus.imem_req_valid !== 1'b1 || imemBus.imem_req_addr !== 64'h8000_0004) begin failures++; $display("FAIL idstall_next_req got=%b/%h exp=1/80000004", imemBus.imem_req_valid, imemBus.imem_req_addr); end
   endtask

   task automatic test_redirect_wait();
      apply_reset();
      memLat = 3;
      imemBus.imem_req_ready = 1'b1;
      idBus.id_ready = 1'b1;
      step();
      step();   // handshake, now in WAIT
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0103;
      step();   // -> FLUSH
      redirect_valid = 1'b0;
      checks++; if (imemBus.imem_req_valid !== 1'b0 || idBus.id_valid !== 1'b0) begin failures++; $display("FAIL rdwait_flush1 got=%b/%b exp=0/0", imemBus.imem_req_valid, idBus.id_valid); end
      step();   // stale response now on the bus
      checks++; if (imemBus.imem_req_valid !== 1'b0 || idBus.id_valid !== 1'b0) begin failures++; $display("FAIL rdwait_flush2 got=%b/%b exp=0/0", imemBus.imem_req_valid, idBus.id_valid); end
      step();   // response dropped -> REQ
      checks++; if (imemBus.imem_req_valid !== 1'b1 || imemBus.imem_req_addr !== 64'h8000_0100) begin failures++; $display("FAIL rdwait_next_req got=%b/%h exp=1/80000100", imemBus.imem_req_valid, imemBus.imem_req_addr); end
      checks++; if (idBus.id_valid !== 1'b0) begin failures++; $display("FAIL rdwait_dropped got=%b exp=0", idBus.id_valid); end
`ifdef IFU_PERF_CNT_EN
      checks++; if (perf_flush_cnt !== 64'd1 || perf_fetch_cnt !== 64'd0) begin failures++; $display("FAIL rdwait_perf got=%0d/%0d exp=1/0", perf_flush_cnt, perf_fetch_cnt); end
`endif
   endtask

   task automatic test_redirect_hold();
      apply_reset();
      imemBus.imem_req_ready = 1'b1;
      idBus.id_ready = 1'b1;
      repeat (3) step();
      checks++; if (idBus.id_valid !== 1'b1 || idBus.id_pc !== 64'h8000_0000) begin failures++; $display("FAIL rdhold_present got=%b/%h exp=1/80000000", idBus.id_valid, idBus.id_pc); end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      step();
      redirect_valid = 1'b0;
      checks++; if (imemBus.imem_req_valid !== 1'b1 || imemBus.imem_req_addr !== 64'h8000_2000) begin failures++; $display("FAIL rdhold_req got=%b/%h exp=1/80002000", imemBus.imem_req_valid, imemBus.imem_req_addr); end
      checks++; if (idBus.id_valid !== 1'b0) begin failures++; $display("FAIL rdhold_id_valid got=%b exp=0", idBus.id_valid); end
`ifdef IFU_PERF_CNT_EN
      checks++; if (perf_fetch_cnt !== 64'd1) begin failures++; $display("FAIL rdhold_perf_fetch got=%0d exp=1", perf_fetch_cnt); end
`endif
      step();
      step();
      checks++; if (idBus.id_valid !== 1'b1 || idBus.id_pc !== 64'h8000_2000 || idBus.id_inst !== 32'hCAFE_2000) begin failures++; $display("FAIL rdhold_target got=%b/%h/%h exp=1/80002000/cafe2000", idBus.id_valid, idBus.id_pc, idBus.id_inst); end
   endtask

   task automatic test_redirect_req();
      apply_reset();
      idBus.id_ready = 1'b1;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0040;
      step();   // no handshake: retarget, stay in REQ
      checks++; if (imemBus.imem_req_valid !== 1'b1 || imemBus.imem_req_addr !== 64'h8000_0040) begin failures++; $display("FAIL rdreq_nohs got=%b/%h exp=1/80000040", imemBus.imem_req_valid, imemBus.imem_req_addr); end
      imemBus.imem_req_ready = 1'b1;
      redirect_pc = 64'h8000_0082;
      step();   // handshake + redirect -> FLUSH
      redirect_valid = 1'b0;
      checks++; if (imemBus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rdreq_hs_flush got=%b exp=0", imemBus.imem_req_valid); end
      step();
      checks++; if (imemBus.imem_req_valid !== 1'b1 || imemBus.imem_req_addr !== 64'h8000_0080) begin failures++; $display("FAIL rdreq_next got=%b/%h exp=1/80000080", imemBus.imem_req_valid, imemBus.imem_req_addr); end
      checks++; if (idBus.id_valid !== 1'b0) begin failures++; $display("FAIL rdreq_dropped got=%b exp=0", idBus.id_valid); end
`ifdef IFU_PERF_CNT_EN
      checks++; if (perf_flush_cnt !== 64'd1) begin failures++; $display("FAIL rdreq_perf_flush got=%0d exp=1", perf_flush_cnt); end
`endif
   endtask

   task automatic test_wrap();
      apply_reset();
      idBus.id_ready = 1'b1;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
      step();
      redirect_valid = 1'b0;
      checks++; if (imemBus.imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_aligned got=%h exp=fffffffffffffffc", imemBus.imem_req_addr); end
      imemBus.imem_req_ready = 1'b1;
      step();
      step();
      checks++; if (idBus.id_valid !== 1'b1 || idBus.id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || idBus.id_inst !== 32'hCAFE_FFFC) begin failures++; $display("FAIL wrap_id got=%b/%h/%h exp=1/fffffffffffffffc/cafefffc", idBus.id_valid, idBus.id_pc, idBus.id_inst); end
      step();
      checks++; if (imemBus.imem_req_valid !== 1'b1 || imemBus.imem_req_addr !== 64'h0) begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/0", imemBus.imem_req_valid, imemBus.imem_req_addr); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      memAuto = 1'b0;
      imemBus.imem_req_ready = 1'b1;
      idBus.id_ready = 1'b1;
      step();
      step();   // accepted, now in WAIT
      rst_n = 1'b0;
      #1;
      checks++; if (imemBus.imem_req_valid !== 1'b0 || imemBus.imem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL rstmid_req got=%b/%h exp=0/80000000", imemBus.imem_req_valid, imemBus.imem_req_addr); end
      checks++; if (idBus.id_valid !== 1'b0 || idBus.id_pc !== 64'h8000_0000 || idBus.id_inst !== 32'h0000_0013) begin failures++; $display("FAIL rstmid_id got=%b/%h/%h exp=0/80000000/00000013", idBus.id_valid, idBus.id_pc, idBus.id_inst); end
      step();
      step();
      rst_n = 1'b1;
      imemBus.imem_resp_valid = 1'b1;
      imemBus.imem_resp_inst  = 32'hDEAD_BEEF;
      step();   // late response lands in BOOT and must be ignored
      checks++; if (imemBus.imem_req_valid !== 1'b1 || imemBus.imem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL rstmid_first_req got=%b/%h exp=1/80000000", imemBus.imem_req_valid, imemBus.imem_req_addr); end
      checks++; if (idBus.id_valid !== 1'b0 || idBus.id_inst !== 32'h0000_0013) begin failures++; $display("FAIL rstmid_ignored got=%b/%h exp=0/00000013", idBus.id_valid, idBus.id_inst); end
      step();
      step();   // in WAIT with no response: nothing may appear
      checks++; if (idBus.id_valid !== 1'b0 || imemBus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_wait got=%b/%b exp=0/0", idBus.id_valid, imemBus.imem_req_valid); end
`ifdef IFU_PERF_CNT_EN
      checks++; if (perf_fetch_cnt !== 64'd0 || perf_flush_cnt !== 64'd0) begin failures++; $display("FAIL rstmid_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_flush_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_stream();
      test_req_stall();
      test_decode_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_redirect_req();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
